risc_seq_ctrl: RTL and testbench

//  Fetch/sequence controller for the 32-bit RISC datapath (GPR file, SGPR, condition flags).

---
 rtl/risc_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_risc_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_seq_ctrl.sv
// rtl/risc_seq_ctrl.sv - fetch/decode/execute sequencer driving IR into the RISC datapath
module risc_seq_ctrl #(
    parameter int AW          = 8,
    parameter int EXEC_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_valid,
    input  logic [31:0]   imem_rdata,
    output logic [31:0]   ir_out,
    output logic          ir_load,
    input  logic          dp_sign,
    input  logic          dp_zero,
    input  logic          dp_carry,
    input  logic          dp_overflow,
    output logic [3:0]    flags_q,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_NEXT, S_HALT
    } state_t;

    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);
    localparam logic [4:0] OP_DP_MAX = 5'b01011;
    localparam logic [4:0] OP_HALT   = 5'b10101;

    state_t      state;
    logic [31:0] fetch_buf;
    logic [3:0]  cnt;
    logic        taken;
    logic        cond;
    logic [4:0]  oper;

    assign oper      = fetch_buf[31:27];
    assign imem_addr = pc;

    // flags_q layout: [3] sign, [2] zero, [1] carry, [0] overflow
    always_comb begin
        cond = 1'b0;
        case (oper)
            5'b01100: cond = 1'b1;
            5'b01101: cond = flags_q[1];
            5'b01110: cond = ~flags_q[1];
            5'b01111: cond = flags_q[3];
            5'b10000: cond = ~flags_q[3];
            5'b10001: cond = flags_q[2];
            5'b10010: cond = ~flags_q[2];
            5'b10011: cond = flags_q[0];
            5'b10100: cond = ~flags_q[0];
            default:  cond = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            ir_out    <= '0;
            flags_q   <= '0;
            imem_req  <= 1'b0;
            ir_load   <= 1'b0;
            busy      <= 1'b0;
            halted    <= 1'b0;
            fetch_buf <= '0;
            cnt       <= '0;
            taken     <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state    <= S_FETCH;
                        pc       <= '0;
                        imem_req <= 1'b1;
                        busy     <= 1'b1;
                        halted   <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        fetch_buf <= imem_rdata;
                        imem_req  <= 1'b0;
                        state     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    taken <= cond;
                    if (oper <= OP_DP_MAX) begin
                        ir_out  <= fetch_buf;
                        ir_load <= 1'b1;
                        cnt     <= '0;
                        state   <= S_EXEC;
                    end else if (oper == OP_HALT) begin
                        busy   <= 1'b0;
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_EXEC: begin
                    ir_load <= 1'b0;
                    if (cnt == EXEC_LAST) begin
                        flags_q <= {dp_sign, dp_zero, dp_carry, dp_overflow};
                        state   <= S_NEXT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    // target is the truncated isrc field; pc wraps naturally at 2^AW
                    pc       <= taken ? fetch_buf[AW-1:0] : pc + 1'b1;
                    imem_req <= 1'b1;
                    state    <= S_FETCH;
                end
                default: begin
                    state    <= S_IDLE;
                    imem_req <= 1'b0;
                    ir_load  <= 1'b0;
                    busy     <= 1'b0;
                    halted   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_risc_seq_ctrl.sv
// tb/tb_risc_seq_ctrl.sv - randomized instruction-level model check of risc_seq_ctrl
module tb_risc_seq_ctrl;
    localparam int AW = 8;
    localparam int E  = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_valid = 1'b0;
    logic [31:0]   imem_rdata = '0;
    logic [31:0]   ir_out;
    logic          ir_load;
    logic          dp_sign = 1'b0, dp_zero = 1'b0, dp_carry = 1'b0, dp_overflow = 1'b0;
    logic [3:0]    flags_q;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;

    risc_seq_ctrl #(.AW(AW), .EXEC_CYCLES(E)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .ir_out(ir_out), .ir_load(ir_load),
        .dp_sign(dp_sign), .dp_zero(dp_zero), .dp_carry(dp_carry), .dp_overflow(dp_overflow),
        .flags_q(flags_q), .pc(pc), .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    logic chk_en = 1'b0;
    int fl_force = -1;

    // architectural model state, also the per-cycle expectation
    logic          e_req, e_load, e_busy, e_halted;
    logic [31:0]   e_ir;
    logic [3:0]    e_flags;
    logic [AW-1:0] e_pc;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("imem_req", 32'(imem_req), 32'(e_req));
            if (e_req) cmp("imem_addr", 32'(imem_addr), 32'(e_pc));
            cmp("ir_out", ir_out, e_ir);
            cmp("ir_load", 32'(ir_load), 32'(e_load));
            cmp("flags_q", 32'(flags_q), 32'(e_flags));
            cmp("pc", 32'(pc), 32'(e_pc));
            cmp("busy", 32'(busy), 32'(e_busy));
            cmp("halted", 32'(halted), 32'(e_halted));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input int op, input int imm);
        mk = {5'(op), 11'($urandom), 16'(imm)};
    endfunction

    function automatic logic br_taken(input logic [4:0] op, input logic [3:0] f);
        logic s, z, c, v;
        {s, z, c, v} = f;
        case (op)
            5'd12:   br_taken = 1'b1;
            5'd13:   br_taken = c;
            5'd14:   br_taken = !c;
            5'd15:   br_taken = s;
            5'd16:   br_taken = !s;
            5'd17:   br_taken = z;
            5'd18:   br_taken = !z;
            5'd19:   br_taken = v;
            5'd20:   br_taken = !v;
            default: br_taken = 1'b0;
        endcase
    endfunction

    task automatic rand_inputs(output logic [3:0] fl);
        fl = (fl_force >= 0) ? fl_force[3:0] : 4'($urandom);
        {dp_sign, dp_zero, dp_carry, dp_overflow} = fl;
        start      = 1'($urandom);
        imem_valid = 1'($urandom);
        imem_rdata = $urandom;
    endtask

    task automatic set_reset_expect();
        e_req = 0; e_load = 0; e_busy = 0; e_halted = 0;
        e_ir = '0; e_flags = '0; e_pc = '0;
    endtask

    task automatic do_start();
        start = 1'b1;
        imem_valid = 1'b0;
        tick();
        start = 1'b0;
        e_pc = '0; e_req = 1; e_busy = 1; e_halted = 0;
    endtask

    // Called in the first FETCH cycle; returns in the next FETCH cycle or in HALT.
    task automatic run_instr(input logic [31:0] w, input int wt);
        logic [4:0] op;
        logic [3:0] fl;
        logic       tk;
        op = w[31:27];
        for (int i = 0; i < wt; i++) begin
            rand_inputs(fl);
            imem_valid = 1'b0;
            tick();
        end
        rand_inputs(fl);
        imem_valid = 1'b1;
        imem_rdata = w;
        tick();
        e_req = 0;
        rand_inputs(fl);
        if (op <= 5'd11) begin
            tick();
            e_ir = w;
            e_load = 1;
            for (int j = 0; j < E; j++) begin
                rand_inputs(fl);
                tick();
                e_load = 0;
                if (j == E - 1) e_flags = fl;
            end
            rand_inputs(fl);
            tick();
            e_pc = e_pc + 1'b1;
            e_req = 1;
        end else if (op == 5'd21) begin
            tick();
            start = 1'b0;
            e_busy = 0;
            e_halted = 1;
        end else begin
            tk = br_taken(op, e_flags);
            tick();
            rand_inputs(fl);
            tick();
            e_pc = tk ? w[AW-1:0] : e_pc + 1'b1;
            e_req = 1;
        end
    endtask

    initial begin
        logic [31:0] add_w;
        logic [31:0] w;
        logic [3:0]  fl;
        set_reset_expect();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        cmp("reset_pc", 32'(pc), 32'h0);
        cmp("reset_busy", 32'(busy), 32'h0);
        tick();

        // mov r1,#5 with zero-wait memory
        fl_force = 4;
        do_start();
        run_instr(mk(1, 5), 0);
        cmp("t1_flags", 32'(flags_q), 32'h4);
        cmp("t1_pc", 32'(pc), 32'h1);

        // delayed imem_valid
        fl_force = -1;
        run_instr(mk(2, 16'h1234), 4);
        cmp("t2_pc", 32'(pc), 32'h2);

        // carry-producing add, then conditional branches on carry
        fl_force = 2;
        add_w = mk(3, 16'hFFFF);
        run_instr(add_w, 0);
        cmp("t3_flags", 32'(flags_q), 32'h2);
        fl_force = -1;
        run_instr(mk(13, 16'h0010), 1);
        cmp("t3_jcarry_pc", 32'(pc), 32'h10);
        run_instr(mk(14, 16'h0040), 0);
        cmp("t3_jnocarry_pc", 32'(pc), 32'h11);

        // jzero not taken; IR untouched by branches
        run_instr(mk(17, 16'h0080), 2);
        cmp("t4_pc", 32'(pc), 32'h12);
        cmp("t4_ir", ir_out, add_w);

        // wrap at 0xFF, then halt at 5 and restart
        run_instr(mk(12, 16'h00FF), 0);
        cmp("t5_jump_pc", 32'(pc), 32'hFF);
        run_instr(mk(4, 16'h0001), 1);
        cmp("t5_wrap_pc", 32'(pc), 32'h0);
        for (int k = 0; k < 5; k++) run_instr(mk((k % 2 == 0) ? 6 : 25, k), k % 3);
        run_instr(mk(21, 0), 0);
        cmp("t5_halted", 32'(halted), 32'h1);
        cmp("t5_halt_pc", 32'(pc), 32'h5);
        repeat (3) begin
            rand_inputs(fl);
            start = 1'b0;
            tick();
        end
        do_start();
        cmp("t5_restart_pc", 32'(pc), 32'h0);

        // randomized program
        for (int n = 0; n < 300; n++) begin
            w = mk($urandom_range(0, 31), $urandom_range(0, 65535));
            run_instr(w, $urandom_range(0, 3));
            if (e_halted) begin
                repeat ($urandom_range(0, 2)) begin
                    rand_inputs(fl);
                    start = 1'b0;
                    tick();
                end
                do_start();
            end
        end

        // reset asserted during EXEC
        imem_valid = 1'b1;
        imem_rdata = mk(5, 16'h00AA);
        tick();
        e_req = 0;
        imem_valid = 1'b0;
        tick();
        e_ir = imem_rdata;
        e_load = 1;
        rst_n = 1'b0;
        #1;
        set_reset_expect();
        cmp("t6_ir", ir_out, 32'h0);
        cmp("t6_load", 32'(ir_load), 32'h0);
        cmp("t6_flags", 32'(flags_q), 32'h0);
        cmp("t6_pc", 32'(pc), 32'h0);
        cmp("t6_busy", 32'(busy), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = mk(12, 16'h0033);
        tick();
        imem_valid = 1'b0;
        tick();
        cmp("t6_req_after", 32'(imem_req), 32'h0);
        cmp("t6_busy_after", 32'(busy), 32'h0);
        tick();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
